// File: rtl/network_interface.sv
// Mesh NoC local network interface: APB completer that turns each access into one request packet
// and completes on the matching response. Optional response timeout under NI_TIMEOUT_EN.
`timescale 1ns/1ps

module network_interface #(
    parameter int ROUTER_ROW       = 0,
    parameter int ROUTER_COL       = 0,
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int APB_PACKET_WIDTH = 12 + DATA_WIDTH + ADDR_WIDTH - 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_psel,
    input  logic                        i_penable,
    input  logic                        i_pwrite,
    input  logic [ADDR_WIDTH-1:0]       i_paddr,
    input  logic [DATA_WIDTH-1:0]       i_pwdata,
    output logic                        o_pready,
    output logic [DATA_WIDTH-1:0]       o_prdata,
    output logic                        o_pslverr,
    output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
    input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket
);

    localparam int DataLo = 12;
    localparam int DataHi = 11 + DATA_WIDTH;
    localparam logic [3:0] SelfId = {2'(ROUTER_ROW), 2'(ROUTER_COL)};

    if (APB_PACKET_WIDTH != 12 + DATA_WIDTH + ADDR_WIDTH - 4) begin : g_width_check
        $error("APB_PACKET_WIDTH must equal 12 + DATA_WIDTH + ADDR_WIDTH - 4");
    end

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_t;

    state_t                      state_q, state_d;
    logic [APB_PACKET_WIDTH-1:0] pkt_q, pkt_d;
    logic [3:0]                  dst_q, dst_d;
    logic                        write_q, write_d;
    logic [DATA_WIDTH-1:0]       prdata_q, prdata_d;
    logic                        pslverr_q, pslverr_d;
    logic [3:0]                  req_dst;
    logic                        rsp_ok;
    logic                        expired;
    logic                        unused_bits;

    assign req_dst = i_paddr[ADDR_WIDTH-1 -: 4];

    // Only a valid response whose source is the node we addressed may complete the transfer.
    assign rsp_ok = i_apbPacket[10] & i_apbPacket[9] & (i_apbPacket[7:4] == dst_q);

    assign unused_bits = ^{i_apbPacket[APB_PACKET_WIDTH-1:DataHi+1], i_apbPacket[8],
                           i_apbPacket[3:0]};

`ifdef NI_TIMEOUT_EN
    localparam int CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntWidth-1:0] tmo_q, tmo_d;

    // Expires on the TIMEOUT_CYCLES-th WAIT cycle; a response in that cycle still wins.
    assign expired = (state_q == StWait) && (tmo_q == CntWidth'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (state_q == StWait && state_d == StWait) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        dst_d     = dst_q;
        write_d   = write_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        unique case (state_q)
            StIdle: begin
                if (i_psel && i_penable) begin
                    if (req_dst == SelfId) begin
                        prdata_d  = '0;
                        pslverr_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        dst_d   = req_dst;
                        write_d = i_pwrite;
                        pkt_d   = {i_paddr[ADDR_WIDTH-5:0],
                                   i_pwrite ? i_pwdata : {DATA_WIDTH{1'b0}},
                                   1'b0, 1'b1, 1'b0, i_pwrite, SelfId, req_dst};
                        state_d = StSend;
                    end
                end
            end
            StSend: state_d = StWait;
            StWait: begin
                if (rsp_ok) begin
                    prdata_d  = write_q ? '0 : i_apbPacket[DataHi:DataLo];
                    pslverr_d = i_apbPacket[11];
                    state_d   = StDone;
                end else if (expired) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            pkt_q     <= '0;
            dst_q     <= '0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            dst_q     <= dst_d;
            write_q   <= write_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign o_pready    = (state_q == StDone);
    assign o_prdata    = o_pready ? prdata_q : '0;
    assign o_pslverr   = o_pready & pslverr_q;
    assign o_apbPacket = (state_q == StSend) ? pkt_q : '0;

endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface: node (0,0) as main DUT, node (2,1) for self-access.
`timescale 1ns/1ps

module tb_network_interface;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int PW = 12 + DW + AW - 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [PW-1:0] pkt_in;

    logic          pready, pslverr, pready_b, pslverr_b;
    logic [DW-1:0] prdata, prdata_b;
    logic [PW-1:0] pkt_out, pkt_out_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] exp_pkt_q[$];
    logic [DW:0]   exp_rsp_q[$];  // {prdata, pslverr}

    always #5 clk = ~clk;

    network_interface #(
        .ROUTER_ROW(0), .ROUTER_COL(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO), .APB_PACKET_WIDTH(PW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(pready), .o_prdata(prdata),
        .o_pslverr(pslverr), .o_apbPacket(pkt_out), .i_apbPacket(pkt_in)
    );

    network_interface #(
        .ROUTER_ROW(2), .ROUTER_COL(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO), .APB_PACKET_WIDTH(PW)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(pready_b), .o_prdata(prdata_b),
        .o_pslverr(pslverr_b), .o_apbPacket(pkt_out_b), .i_apbPacket(pkt_in)
    );

    function automatic logic [PW-1:0] mk_pkt(input logic [1:0] dr, input logic [1:0] dc,
                                             input logic [1:0] sr, input logic [1:0] sc,
                                             input logic wr, input logic rs, input logic vl,
                                             input logic er, input logic [DW-1:0] d,
                                             input logic [AW-5:0] a);
        return {a, d, er, vl, rs, wr, sr, sc, dr, dc};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    endtask

    task automatic do_reset;
        rst = 1; idle_bus(); pkt_in = '0;
        tick(); tick();
        rst = 0;
    endtask

    // Setup phase then access phase; returns in cycle N+1.
    task automatic start_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        tick();
        penable = 1;
        tick();
    endtask

    // Master keeps psel/penable through the DONE cycle, then drops them.
    task automatic finish_access;
        tick();
        idle_bus();
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (pready !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b want 0", pready); end
        n_checks++; if (prdata !== '0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
        n_checks++; if (pkt_out !== '0) begin n_fail++; $display("FAIL reset_packet: got %h want 0", pkt_out); end
        n_checks++; if (pready_b !== 1'b0) begin n_fail++; $display("FAIL reset_pready_b: got %b want 0", pready_b); end
    endtask

    task automatic test_write;
        logic [PW-1:0] ep;
        logic [DW:0]   er;
        int            cyc;
        exp_pkt_q.push_back(mk_pkt(2'd1, 2'd2, 2'd0, 2'd0, 1, 0, 1, 0, 32'h12345678, 12'hABC));
        exp_rsp_q.push_back({32'h0, 1'b0});
        start_access(1, 16'h6ABC, 32'h12345678);
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL write_packet: got %h want %h", pkt_out, ep); end
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL write_pready_send: got %b want 0", pready); end
        tick();
        n_checks++; if (pkt_out !== '0) begin n_fail++; $display("FAIL write_packet_one_cycle: got %h want 0", pkt_out); end
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 1, 1, 1, 0, 32'hCAFEF00D, 12'hABC);
        tick();
        pkt_in = '0;
        wait_ready(cyc);
        er = exp_rsp_q.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL write_latency: got %0d want 0", cyc); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL write_prdata: got %h want %h", prdata, er[DW:1]); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL write_pslverr: got %b want %b", pslverr, er[0]); end
        finish_access();
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL write_pready_drop: got %b want 0", pready); end
        n_checks++; if (pkt_out !== '0) begin n_fail++; $display("FAIL write_no_reaccept: got %h want 0", pkt_out); end
    endtask

    task automatic test_read;
        logic [PW-1:0] ep;
        logic [DW:0]   er;
        int            cyc;
        // Read from (3,3), response three cycles after SEND.
        exp_pkt_q.push_back(mk_pkt(2'd3, 2'd3, 2'd0, 2'd0, 0, 0, 1, 0, 32'h0, 12'h010));
        exp_rsp_q.push_back({32'hDEADBEEF, 1'b0});
        start_access(0, 16'hF010, 32'hFFFFFFFF);
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL read_packet: got %h want %h", pkt_out, ep); end
        tick(); tick();
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL read_pready_wait: got %b want 0", pready); end
        tick();
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd3, 2'd3, 0, 1, 1, 0, 32'hDEADBEEF, 12'h010);
        tick();
        pkt_in = '0;
        wait_ready(cyc);
        er = exp_rsp_q.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL read_latency: got %0d want 0", cyc); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL read_prdata: got %h want %h", prdata, er[DW:1]); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL read_pslverr: got %b want %b", pslverr, er[0]); end
        finish_access();
        n_checks++; if (prdata !== '0) begin n_fail++; $display("FAIL read_prdata_idle: got %h want 0", prdata); end
        // Read from (1,2) with an error response: data and error both pass through.
        exp_pkt_q.push_back(mk_pkt(2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 1, 0, 32'h0, 12'h100));
        exp_rsp_q.push_back({32'h5A5A0001, 1'b1});
        start_access(0, 16'h6100, 32'h0);
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL rderr_packet: got %h want %h", pkt_out, ep); end
        tick();
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 0, 1, 1, 1, 32'h5A5A0001, 12'h100);
        tick();
        pkt_in = '0;
        wait_ready(cyc);
        er = exp_rsp_q.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL rderr_latency: got %0d want 0", cyc); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL rderr_prdata: got %h want %h", prdata, er[DW:1]); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL rderr_pslverr: got %b want %b", pslverr, er[0]); end
        finish_access();
    endtask

    task automatic test_self;
        logic [PW-1:0] ep;
        logic [DW:0]   er;
        do_reset();
        // Node (2,1) addressed to itself; node (0,0) sends a normal request to (2,1).
        exp_pkt_q.push_back(mk_pkt(2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 1, 0, 32'h0, 12'h123));
        start_access(0, 16'h9123, 32'h0);
        n_checks++; if (pready_b !== 1'b1) begin n_fail++; $display("FAIL self_b_pready: got %b want 1", pready_b); end
        n_checks++; if (pslverr_b !== 1'b1) begin n_fail++; $display("FAIL self_b_pslverr: got %b want 1", pslverr_b); end
        n_checks++; if (prdata_b !== '0) begin n_fail++; $display("FAIL self_b_prdata: got %h want 0", prdata_b); end
        n_checks++; if (pkt_out_b !== '0) begin n_fail++; $display("FAIL self_b_packet: got %h want 0", pkt_out_b); end
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL remote_packet: got %h want %h", pkt_out, ep); end
        finish_access();
        n_checks++; if (pready_b !== 1'b0) begin n_fail++; $display("FAIL self_b_pready_drop: got %b want 0", pready_b); end
        n_checks++; if (pkt_out_b !== '0) begin n_fail++; $display("FAIL self_b_no_reaccept: got %h want 0", pkt_out_b); end
        do_reset();
        // Node (0,0) addressed to itself with a write.
        exp_rsp_q.push_back({32'h0, 1'b1});
        start_access(1, 16'h0040, 32'h11111111);
        er = exp_rsp_q.pop_front();
        n_checks++; if (pready !== 1'b1) begin n_fail++; $display("FAIL self_pready: got %b want 1", pready); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL self_pslverr: got %b want %b", pslverr, er[0]); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL self_prdata: got %h want %h", prdata, er[DW:1]); end
        n_checks++; if (pkt_out !== '0) begin n_fail++; $display("FAIL self_packet: got %h want 0", pkt_out); end
        finish_access();
        n_checks++; if (pkt_out !== '0) begin n_fail++; $display("FAIL self_no_reaccept: got %h want 0", pkt_out); end
        do_reset();
    endtask

    task automatic test_filter;
        logic [PW-1:0] ep;
        logic [DW:0]   er;
        logic [PW-1:0] bad[3];
        int            cyc;
        bad[0] = mk_pkt(2'd0, 2'd0, 2'd2, 2'd2, 0, 1, 1, 0, 32'hBAD0BAD0, 12'h004);
        bad[1] = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 0, 0, 1, 0, 32'hBAD1BAD1, 12'h004);
        bad[2] = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 0, 1, 0, 0, 32'hBAD2BAD2, 12'h004);
        exp_pkt_q.push_back(mk_pkt(2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 1, 0, 32'h0, 12'h004));
        exp_rsp_q.push_back({32'h0F0F1234, 1'b0});
        start_access(0, 16'h6004, 32'h0);
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL filter_packet: got %h want %h", pkt_out, ep); end
        tick();
        for (int i = 0; i < 3; i++) begin
            pkt_in = bad[i];
            tick();
            n_checks++;
            if (pready !== 1'b0) begin
                n_fail++; $display("FAIL filter_drop_%0d: pready got %b want 0", i, pready);
            end
        end
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 0, 1, 1, 0, 32'h0F0F1234, 12'h004);
        tick();
        pkt_in = '0;
        wait_ready(cyc);
        er = exp_rsp_q.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL filter_latency: got %0d want 0", cyc); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL filter_prdata: got %h want %h", prdata, er[DW:1]); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL filter_pslverr: got %b want %b", pslverr, er[0]); end
        finish_access();
    endtask

`ifdef NI_TIMEOUT_EN
    task automatic test_timeout;
        logic [PW-1:0] ep;
        logic [DW:0]   er;
        int            cyc;
        // No response: DONE follows the TO-th WAIT cycle, i.e. TO+1 cycles after SEND.
        exp_pkt_q.push_back(mk_pkt(2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 1, 0, 32'h0, 12'h008));
        exp_rsp_q.push_back({32'h0, 1'b1});
        start_access(0, 16'h6008, 32'h0);
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL tmo_packet: got %h want %h", pkt_out, ep); end
        wait_ready(cyc);
        er = exp_rsp_q.pop_front();
        n_checks++; if (cyc !== TO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", cyc, TO + 1); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL tmo_pslverr: got %b want %b", pslverr, er[0]); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL tmo_prdata: got %h want %h", prdata, er[DW:1]); end
        finish_access();
        // Response on the expiry cycle completes without error.
        exp_rsp_q.push_back({32'h00000077, 1'b0});
        start_access(0, 16'h6008, 32'h0);
        repeat (TO) tick();
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", pready); end
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 0, 1, 1, 0, 32'h00000077, 12'h008);
        tick();
        pkt_in = '0;
        er = exp_rsp_q.pop_front();
        n_checks++; if (pready !== 1'b1) begin n_fail++; $display("FAIL tmo_race_pready: got %b want 1", pready); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL tmo_race_pslverr: got %b want %b", pslverr, er[0]); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL tmo_race_prdata: got %h want %h", prdata, er[DW:1]); end
        finish_access();
    endtask
`else
    task automatic test_no_timeout;
        logic [DW:0] er;
        int          early;
        int          cyc;
        early = 0;
        exp_rsp_q.push_back({32'h13579BDF, 1'b0});
        start_access(0, 16'h6008, 32'h0);
        repeat (3 * TO) begin
            tick();
            if (pready !== 1'b0) early++;
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL wait_forever: early pready cycles got %0d want 0", early); end
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 0, 1, 1, 0, 32'h13579BDF, 12'h008);
        tick();
        pkt_in = '0;
        wait_ready(cyc);
        er = exp_rsp_q.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL wait_latency: got %0d want 0", cyc); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL wait_prdata: got %h want %h", prdata, er[DW:1]); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL wait_pslverr: got %b want %b", pslverr, er[0]); end
        finish_access();
    endtask
`endif

    task automatic test_reset_mid;
        logic [PW-1:0] ep;
        logic [DW:0]   er;
        int            cyc;
        int            bad;
        exp_pkt_q.push_back(mk_pkt(2'd3, 2'd0, 2'd0, 2'd0, 1, 0, 1, 0, 32'hAAAA5555, 12'h020));
        start_access(1, 16'hC020, 32'hAAAA5555);
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL rstmid_packet: got %h want %h", pkt_out, ep); end
        tick();
        idle_bus();
        rst = 1;
        tick();
        rst = 0;
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd3, 2'd0, 1, 1, 1, 1, 32'hFFFF0000, 12'h020);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pkt_in = '0;
            if ({pready, pslverr, prdata, pkt_out} !== '0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_outputs_quiet: nonzero cycles got %0d want 0", bad); end
        exp_pkt_q.push_back(mk_pkt(2'd1, 2'd2, 2'd0, 2'd0, 1, 0, 1, 0, 32'h01020304, 12'hDEF));
        exp_rsp_q.push_back({32'h0, 1'b0});
        start_access(1, 16'h6DEF, 32'h01020304);
        ep = exp_pkt_q.pop_front();
        n_checks++; if (pkt_out !== ep) begin n_fail++; $display("FAIL rstmid_new_packet: got %h want %h", pkt_out, ep); end
        tick();
        pkt_in = mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 1, 1, 1, 0, 32'h99999999, 12'hDEF);
        tick();
        pkt_in = '0;
        wait_ready(cyc);
        er = exp_rsp_q.pop_front();
        n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL rstmid_new_latency: got %0d want 0", cyc); end
        n_checks++; if (pslverr !== er[0]) begin n_fail++; $display("FAIL rstmid_new_pslverr: got %b want %b", pslverr, er[0]); end
        n_checks++; if (prdata !== er[DW:1]) begin n_fail++; $display("FAIL rstmid_new_prdata: got %h want %h", prdata, er[DW:1]); end
        finish_access();
    endtask

    initial begin
        idle_bus();
        pkt_in = '0;
        test_reset();
        test_write();
        test_read();
        test_self();
        test_filter();
`ifdef NI_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
